// File: rtl/game_controller.sv
// Game of Life sequencer: debounces the two board buttons and issues load/step pulses
// to the cell grid, with run/pause, single-step, pattern select and auto-pause on a static grid.
module game_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned TICK_DIVIDER    = 23,
  parameter int unsigned N_PATTERNS      = 4,
  parameter int unsigned GEN_WIDTH       = 16,
  localparam int unsigned PatW = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           buttons,
  input  logic                 grid_static,
  output logic                 load_game,
  output logic                 step_game,
  output logic [PatW-1:0]      pattern_sel,
  output logic [GEN_WIDTH-1:0] generation,
  output logic                 running,
  output logic                 stalled
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PatW-1:0] PatLast = PatW'(N_PATTERNS - 1);

  typedef enum logic [1:0] {StLoad, StPause, StRun} state_e;

  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          deb_q, deb_d;
  logic [1:0]          press_q, press_d;
  logic [1:0][DbW-1:0] cnt_q, cnt_d;

  state_e                state_q, state_d;
  logic [PatW-1:0]       pattern_sel_q, pattern_sel_d;
  logic [GEN_WIDTH-1:0]  generation_q, generation_d, gen_inc;
  logic [TICK_DIVIDER-1:0] tick_q, tick_d;
  logic                  load_game_q, load_game_d;
  logic                  step_game_q, step_game_d;
  logic                  running_q, running_d;
  logic                  stalled_q, stalled_d;
  logic                  step_dly_q;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DbLast) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    press_d = deb_d & ~deb_q;
  end

  assign gen_inc = (&generation_q) ? generation_q : generation_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    pattern_sel_d = pattern_sel_q;
    generation_d  = generation_q;
    tick_d        = tick_q;
    stalled_d     = stalled_q;
    load_game_d   = 1'b0;
    step_game_d   = 1'b0;
    unique case (state_q)
      StLoad: begin
        load_game_d  = 1'b1;
        generation_d = '0;
        stalled_d    = 1'b0;
        state_d      = StPause;
      end
      StPause: begin
        if (press_q[0]) begin
          state_d = StRun;
          tick_d  = '0;
        end else if (press_q[1]) begin
          step_game_d  = 1'b1;
          generation_d = gen_inc;
          stalled_d    = 1'b0;
        end
      end
      StRun: begin
        tick_d = tick_q + 1'b1;
        if (press_q[1]) begin
          pattern_sel_d = (pattern_sel_q == PatLast) ? '0 : pattern_sel_q + 1'b1;
          state_d       = StLoad;
        end else begin
          if (&tick_q) begin
            step_game_d  = 1'b1;
            generation_d = gen_inc;
            stalled_d    = 1'b0;
          end
          if (press_q[0]) begin
            state_d = StPause;
          end
          // grid_static reflects the generation produced by the previous step pulse
          if (step_dly_q && grid_static) begin
            state_d   = StPause;
            stalled_d = 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      deb_q         <= '0;
      cnt_q         <= '0;
      press_q       <= '0;
      state_q       <= StLoad;
      pattern_sel_q <= '0;
      generation_q  <= '0;
      tick_q        <= '0;
      load_game_q   <= 1'b0;
      step_game_q   <= 1'b0;
      running_q     <= 1'b0;
      stalled_q     <= 1'b0;
      step_dly_q    <= 1'b0;
    end else begin
      sync1_q       <= buttons;
      sync2_q       <= sync1_q;
      deb_q         <= deb_d;
      cnt_q         <= cnt_d;
      press_q       <= press_d;
      state_q       <= state_d;
      pattern_sel_q <= pattern_sel_d;
      generation_q  <= generation_d;
      tick_q        <= tick_d;
      load_game_q   <= load_game_d;
      step_game_q   <= step_game_d;
      running_q     <= running_d;
      stalled_q     <= stalled_d;
      step_dly_q    <= step_game_q;
    end
  end

  assign load_game   = load_game_q;
  assign step_game   = step_game_q;
  assign pattern_sel = pattern_sel_q;
  assign generation  = generation_q;
  assign running     = running_q;
  assign stalled     = stalled_q;

endmodule
